// File: rtl/mem_req_arbiter_if.sv
// ============================================================================
//  Module      : mem_req_arbiter_if
//  Description : Transaction bus between the request arbiter and memctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_req_arbiter_if;
    logic        mc_valid;
    logic        mc_wr;
    logic [2:0]  mc_width;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic        mc_received;
    logic        mc_done;
    logic [31:0] mc_rdata;

    modport master (
        output mc_valid, mc_wr, mc_width, mc_addr, mc_wdata,
        input  mc_received, mc_done, mc_rdata
    );

    modport slave (
        input  mc_valid, mc_wr, mc_width, mc_addr, mc_wdata,
        output mc_received, mc_done, mc_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
// ============================================================================
//  Module      : mem_req_arbiter
//  Description : Two-slot request arbiter/sequencer in front of memctrl with
//                flush handling. Optional icache starvation guard is enabled
//                by defining ARB_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_all,

    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_ack,
    output logic        ic_done,
    output logic [31:0] ic_data,

    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [2:0]  ls_width,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic        ls_done,
    output logic [31:0] ls_rdata,

    mem_req_arbiter_if.master mc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic       c_OWN_IC     = 1'b0;
    localparam logic       c_OWN_LS     = 1'b1;
    localparam logic [2:0] c_WIDTH_WORD = 3'b010;

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
            $error("mem_req_arbiter: STARVE_LIMIT must be in 1..15");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_owner;
    logic        r_discard;

    logic        r_ic_pend;
    logic [31:0] r_ic_pend_addr;
    logic        r_ls_pend;
    logic        r_ls_pend_wr;
    logic [2:0]  r_ls_pend_width;
    logic [31:0] r_ls_pend_addr;
    logic [31:0] r_ls_pend_wdata;

    logic        r_mc_valid;
    logic        r_mc_wr;
    logic [2:0]  r_mc_width;
    logic [31:0] r_mc_addr;
    logic [31:0] r_mc_wdata;

    logic        r_ic_ack;
    logic        r_ic_done;
    logic [31:0] r_ic_data;
    logic        r_ls_ack;
    logic        r_ls_done;
    logic [31:0] r_ls_rdata;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic        w_owner_nxt;
    logic        w_discard_nxt;

    logic        w_ic_pend_nxt;
    logic [31:0] w_ic_pend_addr_nxt;
    logic        w_ls_pend_nxt;
    logic        w_ls_pend_wr_nxt;
    logic [2:0]  w_ls_pend_width_nxt;
    logic [31:0] w_ls_pend_addr_nxt;
    logic [31:0] w_ls_pend_wdata_nxt;

    logic        w_mc_valid_nxt;
    logic        w_mc_wr_nxt;
    logic [2:0]  w_mc_width_nxt;
    logic [31:0] w_mc_addr_nxt;
    logic [31:0] w_mc_wdata_nxt;

    logic        w_ic_ack_nxt;
    logic        w_ic_done_nxt;
    logic [31:0] w_ic_data_nxt;
    logic        w_ls_ack_nxt;
    logic        w_ls_done_nxt;
    logic [31:0] w_ls_rdata_nxt;

    logic        w_ic_cand;
    logic        w_ls_cand;
    logic        w_pick_ic;
    logic        w_spec_owner;
    logic        w_flush_spec;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_cnt_nxt;
`endif

    // A flush in the same cycle removes speculative candidates before they
    // can be granted; only a held store survives.
    assign w_ic_cand = r_ic_pend && !clear_all;
    assign w_ls_cand = r_ls_pend && !(clear_all && !r_ls_pend_wr);

`ifdef ARB_STARVE_GUARD_EN
    assign w_pick_ic = w_ic_cand && (!w_ls_cand || (r_starve_cnt >= c_STARVE_LIMIT));
`else
    assign w_pick_ic = w_ic_cand && !w_ls_cand;
`endif

    assign w_spec_owner = (r_owner == c_OWN_IC) || !r_mc_wr;
    assign w_flush_spec = clear_all && w_spec_owner;

    always_comb begin
        w_state_nxt         = r_state;
        w_owner_nxt         = r_owner;
        w_discard_nxt       = r_discard;
        w_ic_pend_nxt       = r_ic_pend;
        w_ic_pend_addr_nxt  = r_ic_pend_addr;
        w_ls_pend_nxt       = r_ls_pend;
        w_ls_pend_wr_nxt    = r_ls_pend_wr;
        w_ls_pend_width_nxt = r_ls_pend_width;
        w_ls_pend_addr_nxt  = r_ls_pend_addr;
        w_ls_pend_wdata_nxt = r_ls_pend_wdata;
        w_mc_valid_nxt      = r_mc_valid;
        w_mc_wr_nxt         = r_mc_wr;
        w_mc_width_nxt      = r_mc_width;
        w_mc_addr_nxt       = r_mc_addr;
        w_mc_wdata_nxt      = r_mc_wdata;
        w_ic_ack_nxt        = 1'b0;
        w_ic_done_nxt       = 1'b0;
        w_ic_data_nxt       = '0;
        w_ls_ack_nxt        = 1'b0;
        w_ls_done_nxt       = 1'b0;
        w_ls_rdata_nxt      = '0;
`ifdef ARB_STARVE_GUARD_EN
        w_starve_cnt_nxt    = r_starve_cnt;
`endif

        if (clear_all) begin
            w_ic_pend_nxt = 1'b0;
            if (!r_ls_pend_wr) begin
                w_ls_pend_nxt = 1'b0;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_ic_cand || w_ls_cand) begin
                    w_mc_valid_nxt = 1'b1;
                    w_state_nxt    = ST_ISSUE;
                    if (w_pick_ic) begin
                        w_owner_nxt    = c_OWN_IC;
                        w_mc_wr_nxt    = 1'b0;
                        w_mc_width_nxt = c_WIDTH_WORD;
                        w_mc_addr_nxt  = r_ic_pend_addr;
                        w_mc_wdata_nxt = '0;
                        w_ic_pend_nxt  = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
                        w_starve_cnt_nxt = '0;
`endif
                    end else begin
                        w_owner_nxt    = c_OWN_LS;
                        w_mc_wr_nxt    = r_ls_pend_wr;
                        w_mc_width_nxt = r_ls_pend_width;
                        w_mc_addr_nxt  = r_ls_pend_addr;
                        w_mc_wdata_nxt = r_ls_pend_wdata;
                        w_ls_pend_nxt  = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
                        if (w_ic_cand) begin
                            w_starve_cnt_nxt = (r_starve_cnt == 4'hF) ? r_starve_cnt
                                                                      : r_starve_cnt + 4'd1;
                        end else begin
                            w_starve_cnt_nxt = '0;
                        end
`endif
                    end
                end
            end

            ST_ISSUE: begin
                if (mc.mc_received) begin
                    // Already accepted downstream: let it finish, drop the result.
                    w_mc_valid_nxt = 1'b0;
                    w_state_nxt    = ST_WAIT;
                    if (w_flush_spec) begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (w_flush_spec) begin
                    w_mc_valid_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (mc.mc_done) begin
                    w_state_nxt   = ST_IDLE;
                    w_discard_nxt = 1'b0;
                    if (!r_discard && !w_flush_spec) begin
                        if (r_owner == c_OWN_IC) begin
                            w_ic_done_nxt = 1'b1;
                            w_ic_data_nxt = mc.mc_rdata;
                        end else begin
                            w_ls_done_nxt  = 1'b1;
                            w_ls_rdata_nxt = mc.mc_rdata;
                        end
                    end
                end else if (w_flush_spec) begin
                    w_discard_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_mc_valid_nxt = 1'b0;
                w_discard_nxt  = 1'b0;
            end
        endcase

        // Capture only into a slot that is empty before this edge, so this
        // never collides with a grant clearing the same slot.
        if (ic_req && !r_ic_pend && !clear_all) begin
            w_ic_pend_nxt      = 1'b1;
            w_ic_pend_addr_nxt = ic_addr;
            w_ic_ack_nxt       = 1'b1;
        end

        if (ls_req && !r_ls_pend && !clear_all) begin
            w_ls_pend_nxt       = 1'b1;
            w_ls_pend_wr_nxt    = ls_wr;
            w_ls_pend_width_nxt = ls_width;
            w_ls_pend_addr_nxt  = ls_addr;
            w_ls_pend_wdata_nxt = ls_wdata;
            w_ls_ack_nxt        = 1'b1;
        end
    end

    // rdy_in low freezes every register, which also stretches pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state         <= ST_IDLE;
            r_owner         <= c_OWN_IC;
            r_discard       <= 1'b0;
            r_ic_pend       <= 1'b0;
            r_ic_pend_addr  <= '0;
            r_ls_pend       <= 1'b0;
            r_ls_pend_wr    <= 1'b0;
            r_ls_pend_width <= '0;
            r_ls_pend_addr  <= '0;
            r_ls_pend_wdata <= '0;
            r_mc_valid      <= 1'b0;
            r_mc_wr         <= 1'b0;
            r_mc_width      <= '0;
            r_mc_addr       <= '0;
            r_mc_wdata      <= '0;
            r_ic_ack        <= 1'b0;
            r_ic_done       <= 1'b0;
            r_ic_data       <= '0;
            r_ls_ack        <= 1'b0;
            r_ls_done       <= 1'b0;
            r_ls_rdata      <= '0;
`ifdef ARB_STARVE_GUARD_EN
            r_starve_cnt    <= '0;
`endif
        end else if (rdy_in) begin
            r_state         <= w_state_nxt;
            r_owner         <= w_owner_nxt;
            r_discard       <= w_discard_nxt;
            r_ic_pend       <= w_ic_pend_nxt;
            r_ic_pend_addr  <= w_ic_pend_addr_nxt;
            r_ls_pend       <= w_ls_pend_nxt;
            r_ls_pend_wr    <= w_ls_pend_wr_nxt;
            r_ls_pend_width <= w_ls_pend_width_nxt;
            r_ls_pend_addr  <= w_ls_pend_addr_nxt;
            r_ls_pend_wdata <= w_ls_pend_wdata_nxt;
            r_mc_valid      <= w_mc_valid_nxt;
            r_mc_wr         <= w_mc_wr_nxt;
            r_mc_width      <= w_mc_width_nxt;
            r_mc_addr       <= w_mc_addr_nxt;
            r_mc_wdata      <= w_mc_wdata_nxt;
            r_ic_ack        <= w_ic_ack_nxt;
            r_ic_done       <= w_ic_done_nxt;
            r_ic_data       <= w_ic_data_nxt;
            r_ls_ack        <= w_ls_ack_nxt;
            r_ls_done       <= w_ls_done_nxt;
            r_ls_rdata      <= w_ls_rdata_nxt;
`ifdef ARB_STARVE_GUARD_EN
            r_starve_cnt    <= w_starve_cnt_nxt;
`endif
        end
    end

    assign ic_ack   = r_ic_ack;
    assign ic_done  = r_ic_done;
    assign ic_data  = r_ic_data;
    assign ls_ack   = r_ls_ack;
    assign ls_done  = r_ls_done;
    assign ls_rdata = r_ls_rdata;

    assign mc.mc_valid = r_mc_valid;
    assign mc.mc_wr    = r_mc_wr;
    assign mc.mc_width = r_mc_width;
    assign mc.mc_addr  = r_mc_addr;
    assign mc.mc_wdata = r_mc_wdata;

endmodule

`default_nettype wire
